// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD write scheduler: FSM states, operation
// kinds, HD44780-style command bytes and the logical-position to DDRAM address map.
package lcd_pkg;

  typedef enum logic [2:0] {IDLE, SELECT, ISSUE, WAIT_BUSY, WAIT_DONE} state_e;
  typedef enum logic [1:0] {OP_CHAR, OP_CLEAR, OP_BKSP} op_e;

  localparam logic [7:0] CMD_CLEAR  = 8'h01;
  localparam logic [7:0] CMD_LINE0  = 8'h80;
  localparam logic [7:0] CMD_LINE1  = 8'hC0;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } drv_byte_t;

  // Set-DDRAM-address command for logical position p on a two-line display.
  function automatic logic [7:0] lcd_addr(input logic [5:0] p, input int cols);
    logic [5:0] c;
    c = 6'(cols);
    return (p < c) ? (CMD_LINE0 + 8'(p)) : (CMD_LINE1 + 8'(p - c));
  endfunction

endpackage

// File: rtl/char_fifo.sv
// Character queue: synchronous push/pop, pop frees space for a same-cycle push,
// flush empties the queue and discards any same-cycle push.
module char_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0]   cnt_q;
  logic          do_pop, do_push;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign dout    = mem_q[rd_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/lcd_write_scheduler.sv
// Turns character / clear / backspace requests into a paced stream of LCD driver
// writes, tracking the logical cursor across two display lines.
module lcd_write_scheduler
  import lcd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int COLS       = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] CHAR_IN,
  input  logic       CHAR_VALID,
  input  logic       CLEAR_REQ,
  input  logic       BKSP_REQ,
  input  logic       DRV_BUSY,
  output logic       DRV_WRITE,
  output logic       DRV_RS,
  output logic [7:0] DRV_DATA,
  output logic [5:0] CURSOR,
  output logic       FIFO_FULL,
  output logic       OVERFLOW
);

  localparam logic [5:0] LAST  = 6'(2*COLS-1);
  localparam logic [5:0] COLS6 = 6'(COLS);

  state_e     state_q, state_d;
  op_e        op;
  logic       clr_pend_q, clr_pend_d, bksp_pend_q, bksp_pend_d;
  logic       clr_svc, bksp_svc;
  logic [5:0] cursor_q, cursor_d;
  logic       wrapped_q, wrapped_d;
  logic       ovf_q, ovf_d;
  drv_byte_t  seq_q [4];
  drv_byte_t  seq_d [4];
  logic [1:0] seq_len_q, seq_len_d, seq_idx_q, seq_idx_d;
  logic       rs_q, rs_d;
  logic [7:0] data_q, data_d;
  logic [1:0] k;
  logic [7:0] addr;
  logic       fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [7:0] fifo_dout;

  char_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (CHAR_VALID),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .din   (CHAR_IN),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    cursor_d   = cursor_q;
    wrapped_d  = wrapped_q;
    seq_d      = seq_q;
    seq_len_d  = seq_len_q;
    seq_idx_d  = seq_idx_q;
    rs_d       = rs_q;
    data_d     = data_q;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    clr_svc    = 1'b0;
    bksp_svc   = 1'b0;
    DRV_WRITE  = 1'b0;
    k          = 2'd0;
    addr       = lcd_addr(cursor_q - 6'd1, COLS);
    op         = clr_pend_q ? OP_CLEAR : (bksp_pend_q ? OP_BKSP : OP_CHAR);

    case (state_q)
      IDLE: if (clr_pend_q || bksp_pend_q || !fifo_empty) state_d = SELECT;
      SELECT: begin
        state_d   = ISSUE;
        seq_idx_d = 2'd0;
        case (op)
          OP_CLEAR: begin
            clr_svc    = 1'b1;
            fifo_flush = 1'b1;
            cursor_d   = '0;
            wrapped_d  = 1'b0;
            seq_d[0]   = '{rs: 1'b0, data: CMD_CLEAR};
            seq_len_d  = 2'd1;
          end
          OP_BKSP: begin
            bksp_svc = 1'b1;
            if (cursor_q == '0) begin
              state_d = IDLE;
            end else begin
              seq_d[0]  = '{rs: 1'b0, data: addr};
              seq_d[1]  = '{rs: 1'b1, data: CHAR_SPACE};
              seq_d[2]  = '{rs: 1'b0, data: addr};
              seq_len_d = 2'd3;
              cursor_d  = cursor_q - 6'd1;
            end
          end
          default: begin
            fifo_pop = 1'b1;
            // Line changes need an explicit address: after column COLS-1 and after wrap.
            if (cursor_q == COLS6) begin
              seq_d[0] = '{rs: 1'b0, data: CMD_LINE1};
              k        = 2'd1;
            end else if (cursor_q == '0 && wrapped_q) begin
              seq_d[0]  = '{rs: 1'b0, data: CMD_LINE0};
              k         = 2'd1;
              wrapped_d = 1'b0;
            end
            seq_d[k]  = '{rs: 1'b1, data: fifo_dout};
            seq_len_d = k + 2'd1;
            if (cursor_q == LAST) begin
              cursor_d  = '0;
              wrapped_d = 1'b1;
            end else begin
              cursor_d = cursor_q + 6'd1;
            end
          end
        endcase
        if (state_d == ISSUE) {rs_d, data_d} = seq_d[0];
      end
      ISSUE: if (!DRV_BUSY) begin
        DRV_WRITE = 1'b1;
        seq_idx_d = seq_idx_q + 2'd1;
        state_d   = WAIT_BUSY;
      end
      WAIT_BUSY: if (DRV_BUSY) state_d = WAIT_DONE;
      WAIT_DONE: if (!DRV_BUSY) begin
        if (seq_idx_q < seq_len_q) begin
          state_d        = ISSUE;
          {rs_d, data_d} = seq_q[seq_idx_q];
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    clr_pend_d  = (clr_pend_q & ~clr_svc) | CLEAR_REQ;
    bksp_pend_d = (bksp_pend_q & ~bksp_svc) | BKSP_REQ;
    // A character lost to the clear flush is not an overflow.
    if (clr_svc)                                  ovf_d = 1'b0;
    else if (CHAR_VALID && fifo_full && !fifo_pop) ovf_d = 1'b1;
    else                                          ovf_d = ovf_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      clr_pend_q  <= 1'b0;
      bksp_pend_q <= 1'b0;
      cursor_q    <= '0;
      wrapped_q   <= 1'b0;
      ovf_q       <= 1'b0;
      seq_len_q   <= '0;
      seq_idx_q   <= '0;
      rs_q        <= 1'b0;
      data_q      <= '0;
      for (int i = 0; i < 4; i++) seq_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      clr_pend_q  <= clr_pend_d;
      bksp_pend_q <= bksp_pend_d;
      cursor_q    <= cursor_d;
      wrapped_q   <= wrapped_d;
      ovf_q       <= ovf_d;
      seq_len_q   <= seq_len_d;
      seq_idx_q   <= seq_idx_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
      seq_q       <= seq_d;
    end
  end

  assign DRV_RS    = rs_q;
  assign DRV_DATA  = data_q;
  assign CURSOR    = cursor_q;
  assign FIFO_FULL = fifo_full;
  assign OVERFLOW  = ovf_q;

endmodule

// File: tb/tb_lcd_write_scheduler.sv
// Bench for lcd_write_scheduler: a bench-side LCD driver, a queue-based reference
// model checked every cycle, directed scenarios and a randomized soak.
module tb_lcd_write_scheduler;

  localparam int D = 4;
  localparam int C = 16;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] CHAR_IN;
  logic       CHAR_VALID, CLEAR_REQ, BKSP_REQ, DRV_BUSY;
  logic       DRV_WRITE, DRV_RS;
  logic [7:0] DRV_DATA;
  logic [5:0] CURSOR;
  logic       FIFO_FULL, OVERFLOW;

  lcd_write_scheduler #(.FIFO_DEPTH(D), .COLS(C)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .CHAR_IN    (CHAR_IN),
    .CHAR_VALID (CHAR_VALID),
    .CLEAR_REQ  (CLEAR_REQ),
    .BKSP_REQ   (BKSP_REQ),
    .DRV_BUSY   (DRV_BUSY),
    .DRV_WRITE  (DRV_WRITE),
    .DRV_RS     (DRV_RS),
    .DRV_DATA   (DRV_DATA),
    .CURSOR     (CURSOR),
    .FIFO_FULL  (FIFO_FULL),
    .OVERFLOW   (OVERFLOW)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: display state as plain variables, pending bytes as a queue.
  logic [7:0] mq[$];
  logic [8:0] exp_q[$];
  bit         m_clr, m_bk, m_wrap, m_ovf;
  int         m_cur;
  bit         m_idle, m_armed, m_infl, m_hi;
  int         stall;
  logic [8:0] last_wr;

  logic [8:0] wlog[$];
  logic [8:0] exp_log[$];
  int         wr_cnt = 0;
  int         seen_wr = 0;
  int         busy_left = 0;
  int         lat = 3;
  bit         force_busy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [7:0] addr_of(input int p);
    return (p < C) ? 8'(8'h80 + p) : 8'(8'hC0 + (p - C));
  endfunction

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    m_clr = 0; m_bk = 0; m_wrap = 0; m_ovf = 0; m_cur = 0;
    m_idle = 1; m_armed = 0; m_infl = 0; m_hi = 0; stall = 0;
  endtask

  // One operation start: fixed priority clear > backspace > queued char.
  task automatic decide(output bit flush_now, output bit svc_c, output bit svc_b);
    logic [7:0] c;
    flush_now = 0; svc_c = 0; svc_b = 0;
    if (m_clr) begin
      svc_c = 1; flush_now = 1;
      mq.delete();
      m_ovf = 0; m_cur = 0; m_wrap = 0;
      exp_q.push_back({1'b0, 8'h01});
    end else if (m_bk) begin
      svc_b = 1;
      if (m_cur > 0) begin
        m_cur--;
        exp_q.push_back({1'b0, addr_of(m_cur)});
        exp_q.push_back({1'b1, 8'h20});
        exp_q.push_back({1'b0, addr_of(m_cur)});
      end
    end else begin
      c = mq.pop_front();
      if (m_cur == C) exp_q.push_back({1'b0, 8'hC0});
      else if (m_cur == 0 && m_wrap) begin
        exp_q.push_back({1'b0, 8'h80});
        m_wrap = 0;
      end
      exp_q.push_back({1'b1, c});
      if (m_cur == 2*C-1) begin m_cur = 0; m_wrap = 1; end
      else m_cur++;
    end
    m_idle = (exp_q.size() == 0);
  endtask

  task automatic step();
    bit flush_now, svc_c, svc_b, op_done;
    flush_now = 0; svc_c = 0; svc_b = 0; op_done = 0;
    if (DRV_WRITE) begin
      chk("write_while_busy", {31'd0, DRV_BUSY}, 32'd0);
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL spurious_write: got rs=%0d data=%02h, expected no write", DRV_RS, DRV_DATA);
      end else begin
        chk("write_byte", {23'd0, DRV_RS, DRV_DATA}, {23'd0, exp_q.pop_front()});
      end
      wlog.push_back({DRV_RS, DRV_DATA});
      last_wr = {DRV_RS, DRV_DATA};
      wr_cnt++;
      m_infl = 1; m_hi = 0; stall = 0;
    end else begin
      if (m_infl) begin
        chk("byte_hold", {23'd0, DRV_RS, DRV_DATA}, {23'd0, last_wr});
        if (DRV_BUSY) m_hi = 1;
        else if (m_hi) begin
          m_infl = 0;
          op_done = (exp_q.size() == 0);
        end
      end
      if (exp_q.size() != 0 && ++stall > 400) begin
        n_chk++; n_fail++;
        $display("FAIL write_timeout: %0d bytes outstanding, expected them written", exp_q.size());
        exp_q.delete();
      end
    end
    if (m_armed) begin
      m_armed = 0;
      decide(flush_now, svc_c, svc_b);
    end else if (m_idle && (m_clr || m_bk || mq.size() > 0)) begin
      m_armed = 1;
    end
    if (op_done) m_idle = 1;
    if (CHAR_VALID && !flush_now) begin
      if (mq.size() < D) mq.push_back(CHAR_IN);
      else m_ovf = 1;
    end
    m_clr = (m_clr && !svc_c) || CLEAR_REQ;
    m_bk  = (m_bk && !svc_b) || BKSP_REQ;
  endtask

  always @(negedge CLK) begin
    if (RST) model_reset();
    chk("cursor", {26'd0, CURSOR}, m_cur);
    chk("fifo_full", {31'd0, FIFO_FULL}, {31'd0, mq.size() == D});
    chk("overflow", {31'd0, OVERFLOW}, {31'd0, m_ovf});
    if (RST) begin
      chk("rst_write", {31'd0, DRV_WRITE}, 32'd0);
      chk("rst_rs_data", {23'd0, DRV_RS, DRV_DATA}, 32'd0);
    end else begin
      step();
    end
  end

  // Bench-side driver: busy from the cycle after each write for lat (or random) cycles.
  task automatic tick();
    @(posedge CLK);
    #1;
    CHAR_VALID = 0; CLEAR_REQ = 0; BKSP_REQ = 0;
    if (wr_cnt != seen_wr) begin
      seen_wr   = wr_cnt;
      busy_left = (lat == 0) ? int'($urandom_range(1, 4)) : lat;
    end
    if (busy_left > 0) begin
      busy_left--;
      DRV_BUSY = 1;
    end else begin
      DRV_BUSY = force_busy;
    end
  endtask

  task automatic send_char(input logic [7:0] c);
    tick();
    CHAR_VALID = 1;
    CHAR_IN    = c;
  endtask

  task automatic wait_quiet(input int max);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (n < max && !(exp_q.size() == 0 && !m_infl && m_idle && !m_armed &&
                            mq.size() == 0 && !m_clr && !m_bk && busy_left == 0));
    chk("quiet_reached", n < max, 1);
  endtask

  task automatic do_reset();
    tick();
    RST = 1;
    tick();
    tick();
    RST = 0;
    wlog.delete();
  endtask

  task automatic check_log(input string name);
    chk({name, "_len"}, wlog.size(), exp_log.size());
    for (int i = 0; i < exp_log.size() && i < wlog.size(); i++)
      chk({name, "_byte"}, {23'd0, wlog[i]}, {23'd0, exp_log[i]});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    RST = 1; CHAR_IN = 0; CHAR_VALID = 0; CLEAR_REQ = 0; BKSP_REQ = 0; DRV_BUSY = 0;
    repeat (3) tick();
    chk("reset_cursor", {26'd0, CURSOR}, 32'd0);
    RST = 0;

    // "HI" with 3-cycle busy
    send_char(8'h48); send_char(8'h49);
    wait_quiet(200);
    exp_log = {9'h148, 9'h149};
    check_log("hi");
    chk("hi_cursor", {26'd0, CURSOR}, 32'd2);

    // 17 chars: line change command before the 17th
    do_reset();
    for (int i = 0; i < 17; i++) begin send_char(8'h41); wait_quiet(200); end
    exp_log.delete();
    for (int i = 0; i < 16; i++) exp_log.push_back(9'h141);
    exp_log.push_back(9'h0C0);
    exp_log.push_back(9'h141);
    check_log("line_wrap");
    chk("line_wrap_cursor", {26'd0, CURSOR}, 32'd17);

    // backspace from cursor 5
    do_reset();
    for (int i = 0; i < 5; i++) begin send_char(8'h78); wait_quiet(200); end
    wlog.delete();
    tick(); BKSP_REQ = 1;
    wait_quiet(200);
    exp_log = {9'h084, 9'h120, 9'h084};
    check_log("bksp");
    chk("bksp_cursor", {26'd0, CURSOR}, 32'd4);

    // clear + backspace together, two chars queued, driver busy
    do_reset();
    for (int i = 0; i < 3; i++) begin send_char(8'h79); wait_quiet(200); end
    wlog.delete();
    force_busy = 1;
    tick(); CHAR_VALID = 1; CHAR_IN = 8'h61; CLEAR_REQ = 1; BKSP_REQ = 1;
    tick(); CHAR_VALID = 1; CHAR_IN = 8'h62;
    repeat (6) tick();
    force_busy = 0;
    wait_quiet(200);
    exp_log = {9'h001};
    check_log("clr_bksp");
    chk("clr_bksp_cursor", {26'd0, CURSOR}, 32'd0);
    chk("clr_bksp_full", {31'd0, FIFO_FULL}, 32'd0);

    // overflow: clear stalled in ISSUE, five chars into a four-deep queue
    do_reset();
    tick(); CLEAR_REQ = 1; force_busy = 1;
    repeat (3) tick();
    for (int i = 0; i < 5; i++) send_char(8'(8'h30 + i));
    tick();
    chk("ovf_full", {31'd0, FIFO_FULL}, 32'd1);
    chk("ovf_flag", {31'd0, OVERFLOW}, 32'd1);
    force_busy = 0;
    wait_quiet(300);
    exp_log = {9'h001, 9'h130, 9'h131, 9'h132, 9'h133};
    check_log("ovf");

    // reset while waiting on the 0xC0 line command
    do_reset();
    for (int i = 0; i < 16; i++) begin send_char(8'h42); wait_quiet(200); end
    lat = 12;
    send_char(8'h5A);
    n = 0;
    while (n < 50 && !(wlog.size() > 0 && wlog[wlog.size()-1] == 9'h0C0)) begin tick(); n++; end
    chk("c0_seen", n < 50, 1);
    tick(); tick();
    RST = 1;
    #2;
    chk("async_write", {31'd0, DRV_WRITE}, 32'd0);
    chk("async_rs_data", {23'd0, DRV_RS, DRV_DATA}, 32'd0);
    chk("async_cursor", {26'd0, CURSOR}, 32'd0);
    chk("async_ovf_full", {30'd0, OVERFLOW, FIFO_FULL}, 32'd0);
    tick(); tick();
    RST = 0;
    n = wlog.size();
    repeat (40) tick();
    chk("no_write_after_rst", wlog.size(), n);
    wait_quiet(100);

    // randomized soak with random driver latency
    lat = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      tick();
      if ($urandom_range(0, 99) < 35) begin CHAR_VALID = 1; CHAR_IN = 8'($urandom_range(32, 126)); end
      if ($urandom_range(0, 99) < 6)  BKSP_REQ = 1;
      if ($urandom_range(0, 199) < 3) CLEAR_REQ = 1;
    end
    wait_quiet(2000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
